// File: rtl/store_buffer.sv
// Posted-write store buffer in front of data_memory: stores queue in a FIFO and drain one per
// cycle; loads use the read port first and stall only on byte overlap with a pending store.

`ifndef RF_XLEN
`define RF_XLEN 32
`endif
`ifndef DM_OPSLEN
`define DM_OPSLEN 3
`endif
`ifndef DM_OPS_LB
`define DM_OPS_LB 3'b000
`endif
`ifndef DM_OPS_LH
`define DM_OPS_LH 3'b001
`endif
`ifndef DM_OPS_LW
`define DM_OPS_LW 3'b010
`endif
`ifndef DM_OPS_LBU
`define DM_OPS_LBU 3'b100
`endif
`ifndef DM_OPS_LHU
`define DM_OPS_LHU 3'b101
`endif
`ifndef DM_OPS_SB
`define DM_OPS_SB 3'b000
`endif
`ifndef DM_OPS_SH
`define DM_OPS_SH 3'b001
`endif
`ifndef DM_OPS_SW
`define DM_OPS_SW 3'b010
`endif

module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [`DM_OPSLEN-1:0] st_op,
  input  logic [`RF_XLEN-1:0]   st_addr,
  input  logic [`RF_XLEN-1:0]   st_wdata,
  input  logic                  ld_req,
  input  logic [`DM_OPSLEN-1:0] ld_op,
  input  logic [`RF_XLEN-1:0]   ld_addr,
  output logic                  ld_stall,
  input  logic                  fence,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic                  dm_rd_en,
  output logic [`DM_OPSLEN-1:0] dm_rd_op,
  output logic                  dm_wr_en,
  output logic [`DM_OPSLEN-1:0] dm_wr_op,
  output logic [`RF_XLEN-1:0]   dm_addr,
  output logic [`RF_XLEN-1:0]   dm_wdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so range ends never wrap at the top of the address space.
  localparam int unsigned AW    = `RF_XLEN + 1;

  logic [`DM_OPSLEN-1:0] op_q    [DEPTH];
  logic [`RF_XLEN-1:0]   addr_q  [DEPTH];
  logic [`RF_XLEN-1:0]   wdata_q [DEPTH];

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] hit;
  logic             conflict, push, pop, rd_grant, has_pending;
  logic [AW-1:0]    ld_lo, ld_hi;

  // Draining is unconditional, so the drain request carries no extra information here.
  logic unused_fence;
  assign unused_fence = fence;

  function automatic logic [2:0] op_size(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign ld_lo = {1'b0, ld_addr};
  assign ld_hi = ld_lo + AW'(op_size(ld_op[1:0]));

  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    logic [AW-1:0] st_lo, st_hi;
    assign st_lo  = {1'b0, addr_q[i]};
    assign st_hi  = st_lo + AW'(op_size(op_q[i][1:0]));
    assign hit[i] = valid_q[i] && (st_lo < ld_hi) && (ld_lo < st_hi);
  end

  assign conflict    = |hit;
  assign has_pending = (count_q != '0);
  assign st_ready    = (count_q != CNT_W'(DEPTH));
  assign empty       = !has_pending;
  assign count       = count_q;
  assign push        = st_valid && st_ready;
  assign rd_grant    = ld_req && !conflict;
  // A conflicting load implies a pending entry, so the head drains to unblock it.
  assign pop         = has_pending && (!ld_req || conflict);
  assign ld_stall    = ld_req && conflict;

  always_comb begin
    dm_rd_en = 1'b0;
    dm_rd_op = '0;
    dm_wr_en = 1'b0;
    dm_wr_op = '0;
    dm_addr  = '0;
    dm_wdata = '0;
    if (rd_grant) begin
      dm_rd_en = 1'b1;
      dm_rd_op = ld_op;
      dm_addr  = ld_addr;
    end else if (pop) begin
      dm_wr_en = 1'b1;
      dm_wr_op = op_q[head_q];
      dm_addr  = addr_q[head_q];
      dm_wdata = wdata_q[head_q];
    end
  end

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      op_q[tail_q]    <= st_op;
      addr_q[tail_q]  <= st_addr;
      wdata_q[tail_q] <= st_wdata;
    end
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the execute/LSU stage and data_memory. Stores are accepted into a FIFO and drained into data_memory's write port one per cycle, whenever the shared address bus is not taken by a load.
- Loads go straight to data_memory's combinational read port and have priority over draining.
- A load whose bytes overlap any pending store is stalled until that store has drained. No forwarding is done.

Parameters:
- DEPTH, 4, number of store entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- st_valid  in  1  store request
- st_ready  out  1  buffer can accept a store
- st_op  in  `DM_OPSLEN  store op: `DM_OPS_SB, `DM_OPS_SH or `DM_OPS_SW
- st_addr  in  `RF_XLEN  store byte address
- st_wdata  in  `RF_XLEN  store data, right-aligned
- ld_req  in  1  load request this cycle
- ld_op  in  `DM_OPSLEN  load op, passed through to data_memory
- ld_addr  in  `RF_XLEN  load byte address
- ld_stall  out  1  load blocked by an overlapping pending store
- fence  in  1  drain request
- empty  out  1  no pending stores
- count  out  CNT_W  number of pending stores
- dm_rd_en  out  1  to data_memory rd_en
- dm_rd_op  out  `DM_OPSLEN  to data_memory rd_op
- dm_wr_en  out  1  to data_memory wr_en
- dm_wr_op  out  `DM_OPSLEN  to data_memory wr_op
- dm_addr  out  `RF_XLEN  to data_memory addr
- dm_wdata  out  `RF_XLEN  to data_memory wdata

Behaviour:
- Storage and reset
  - Circular FIFO of DEPTH entries {op, addr, wdata}, with head/tail pointers and count.
  - rst (async) clears the pointers, count and all entry valid bits immediately. Any pending stores are discarded, including a reset mid-drain.
  - Entry payload is not reset.
- Reset output values: st_ready=1, empty=1, count=0, ld_stall=0, dm_rd_en=0, dm_wr_en=0. dm_addr, dm_wdata, dm_rd_op and dm_wr_op are driven 0 while no request is granted.
- Push
  - Push occurs when st_valid & st_ready at the posedge.
  - st_ready = (count != DEPTH), registered-state only. No push is allowed on a full buffer, even when a pop happens in the same cycle.
- Overlap test for a load
  - Byte ranges: size is 1/2/4 for B(U)/H(U)/W and SB/SH/SW.
  - Overlap if st_addr < ld_addr+lsz and ld_addr < st_addr+ssz, using 33-bit unsigned arithmetic (no wrap).
  - conflict = OR over valid entries of overlap. The store being pushed this same cycle is NOT included.
- Port arbitration (combinational, per cycle)
  - ld_req & !conflict
    - Outputs: dm_rd_en=1, dm_rd_op=ld_op, dm_addr=ld_addr, ld_stall=0, dm_wr_en=0.
    - Effect: no pop.
  - ld_req & conflict
    - Outputs: ld_stall=1, dm_rd_en=0.
    - Effect: head drains this cycle (count>0 is guaranteed).
  - !ld_req & count>0
    - Outputs: dm_wr_en=1, dm_wr_op=head.op, dm_addr=head.addr, dm_wdata=head.wdata.
    - Effect: pop at the posedge, since data_memory writes on the same edge.
  - Otherwise all dm enables are 0.
  - Drain output (any case above where the head drains): dm_wr_en=1 with dm_wr_op/dm_addr/dm_wdata taken from head; pop at the posedge.
- Latency
  - A store accepted at edge N is eligible to drain in cycle N+1; the earliest write to memory is at edge N+1.
  - A stalled load is released the cycle after its last overlapping entry pops.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- Ordering: stores drain strictly in FIFO order, and each store performs exactly one write.
- fence: advisory only; draining is always active. empty = (count==0). The upstream stage holds off until empty.
- Out-of-range addresses (addr[31:10]!=0) are buffered and drained normally. data_memory suppresses the write and flags br/tb; this block takes no action.
- Pointer wrap: modulo DEPTH.

Test Plan:
- Reset, then 4 SW stores (addr 0x0,0x4,0x8,0xC; data 0x11..0x44) with ld_req=0 -> each drains one cycle after push; data_memory holds those words; count returns to 0 and empty=1.
- ld_req held high continuously while 4 stores are pushed -> st_ready=0 after the 4th store; count=4; no dm_wr_en. Drop ld_req -> 4 consecutive writes in FIFO order, then st_ready=1.
- Pending SW 0xDEADBEEF @0x20, then LW @0x20 -> ld_stall=1 for one cycle while the store drains; next cycle dm_rd_en=1 and rdata=0xDEADBEEF.
- Pending SB @0x23, then LH @0x22 -> conflict/stall. Pending SB @0x24, then LH @0x22 -> no stall and the read is granted immediately.
- With count=2, push and drain in the same cycle -> count stays 2. Pointers wrap after 5 pushes with DEPTH=4, and order is preserved.
- Assert rst asynchronously (mid-cycle) with 3 pending entries -> count=0, dm_wr_en=0 immediately, and no further writes occur.
